// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: polynomial codes, sequence lengths, the tap recurrence
// and the generator FSM state type. The checker imports the same tap function.
package prbs_pkg;

    localparam logic [2:0] PRBS3  = 3'd0;
    localparam logic [2:0] PRBS7  = 3'd1;
    localparam logic [2:0] PRBS9  = 3'd2;
    localparam logic [2:0] PRBS11 = 3'd3;
    localparam logic [2:0] PRBS15 = 3'd4;
    localparam logic [2:0] PRBS17 = 3'd5;
    localparam logic [2:0] PRBS23 = 3'd6;
    localparam logic [2:0] PRBS32 = 3'd7;

    localparam logic [31:0] PRBS3_LEN  = 32'd7;
    localparam logic [31:0] PRBS7_LEN  = 32'd127;
    localparam logic [31:0] PRBS9_LEN  = 32'd511;
    localparam logic [31:0] PRBS11_LEN = 32'd2047;
    localparam logic [31:0] PRBS15_LEN = 32'd32767;
    localparam logic [31:0] PRBS17_LEN = 32'd131071;
    localparam logic [31:0] PRBS23_LEN = 32'd8388607;
    localparam logic [31:0] PRBS32_LEN = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tx_state_e;

    // h[0] is the newest bit; the result is the next bit to enter h[0].
    function automatic logic prbs_tap(input logic [2:0] code, input logic [31:0] h);
        logic g;
        case (code)
            PRBS3:   g = h[2]  ^ h[0];
            PRBS7:   g = h[6]  ^ h[0];
            PRBS9:   g = h[8]  ^ h[4];
            PRBS11:  g = h[10] ^ h[8];
            PRBS15:  g = h[14] ^ h[0];
            PRBS17:  g = h[16] ^ h[2];
            PRBS23:  g = h[22] ^ h[17];
            default: g = h[31] ^ h[21] ^ h[1] ^ h[0];
        endcase
        return g;
    endfunction

    function automatic logic [31:0] prbs_seq_len(input logic [2:0] code);
        logic [31:0] len;
        case (code)
            PRBS3:   len = PRBS3_LEN;
            PRBS7:   len = PRBS7_LEN;
            PRBS9:   len = PRBS9_LEN;
            PRBS11:  len = PRBS11_LEN;
            PRBS15:  len = PRBS15_LEN;
            PRBS17:  len = PRBS17_LEN;
            PRBS23:  len = PRBS23_LEN;
            default: len = PRBS32_LEN;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/prbs_tx_gen_if.sv
// Control and serial-output bundle of the PRBS generator. master is the
// generator side; slave is the controller/consumer side.
interface prbs_tx_gen_if #(
    parameter int unsigned ERR_CNT_WIDTH = 16
) ();

    logic                     start;
    logic                     stop;
    logic [7:0]               rate_div;
    logic                     inj_err;
    logic [15:0]              err_period;
    logic                     dout;
    logic                     dout_vld;
    logic                     busy;
    logic                     done;
    logic [31:0]              bits_sent;
    logic [ERR_CNT_WIDTH-1:0] err_injected;

    modport master (
        input  start,
        input  stop,
        input  rate_div,
        input  inj_err,
        input  err_period,
        output dout,
        output dout_vld,
        output busy,
        output done,
        output bits_sent,
        output err_injected
    );

    modport slave (
        output start,
        output stop,
        output rate_div,
        output inj_err,
        output err_period,
        input  dout,
        input  dout_vld,
        input  busy,
        input  done,
        input  bits_sent,
        input  err_injected
    );

endinterface

// File: rtl/prbs_lfsr_core.sv
// PRBS history register with tap feedback. load restarts from SEED in the same
// cycle, so a load+shift emits the first bit of the sequence immediately.
module prbs_lfsr_core
    import prbs_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hFFFF_FFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code,
    input  logic       load,
    input  logic       shift,
    output logic       fb
);

    logic [31:0] h;
    logic [31:0] h_src;

    assign h_src = load ? SEED : h;
    assign fb    = prbs_tap(code, h_src);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= SEED;
        end else if (shift) begin
            h <= {h_src[30:0], fb};
        end else if (load) begin
            h <= SEED;
        end
    end

endmodule

// File: rtl/prbs_tx_gen.sv
// Serial PRBS generator with programmable bit rate, frame length and error
// injection. Injected inversions affect dout only, never the history register.
module prbs_tx_gen
    import prbs_pkg::*;
#(
    parameter int unsigned PRBS_TYPE     = 1,
    parameter logic [31:0] SEED          = 32'hFFFF_FFFF,
    parameter logic [31:0] FRAME_LEN     = 32'd0,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input logic           clk,
    input logic           rst,
    prbs_tx_gen_if.master bus
);

    localparam logic [2:0]               CODE    = 3'(PRBS_TYPE);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

    tx_state_e                state;
    tx_state_e                state_nxt;
    logic [7:0]               rate_cnt;
    logic [15:0]              per_cnt;
    logic                     pending;
    logic                     frame_end;
    logic [31:0]              bits_sent;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;
    logic                     dout_p0;
    logic                     vld_p0;

    logic                     start_ok;
    logic                     strobe;
    logic                     fb;
    logic                     pend_eff;
    logic                     per_fire;
    logic                     inj;
    logic                     last_bit;
    logic [7:0]               rate_load;
    logic [15:0]              per_inc;
    logic [31:0]              bits_nxt;

    prbs_lfsr_core #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .code  (CODE),
        .load  (start_ok),
        .shift (strobe),
        .fb    (fb)
    );

    // The start edge is itself a strobe, giving one cycle of output latency.
    always_comb begin
        start_ok  = (state == ST_IDLE) && bus.start && !bus.stop;
        strobe    = start_ok ||
                    ((state == ST_RUN) && !bus.stop && !frame_end && (rate_cnt == 8'd0));
        rate_load = (bus.rate_div == 8'd0) ? 8'd0 : (bus.rate_div - 8'd1);
        per_inc   = (start_ok ? 16'd0 : per_cnt) + 16'd1;
        // >= keeps the period sane if err_period is lowered below the running count.
        per_fire  = (bus.err_period != 16'd0) && (per_inc >= bus.err_period);
        pend_eff  = pending || bus.inj_err;
        inj       = pend_eff || per_fire;
        bits_nxt  = (start_ok ? 32'd0 : bits_sent) + 32'd1;
        last_bit  = (FRAME_LEN != 32'd0) && (bits_nxt == FRAME_LEN);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_nxt = ST_IDLE;
                end else if (frame_end) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rate_cnt  <= 8'd0;
            per_cnt   <= 16'd0;
            pending   <= 1'b0;
            frame_end <= 1'b0;
            bits_sent <= 32'd0;
            err_cnt   <= '0;
        end else begin
            state <= state_nxt;

            if (strobe) begin
                rate_cnt <= rate_load;
            end else if ((state == ST_RUN) && (rate_cnt != 8'd0)) begin
                rate_cnt <= rate_cnt - 8'd1;
            end

            if (strobe) begin
                per_cnt <= per_fire ? 16'd0 : per_inc;
            end

            // A request is held until the next bit consumes it; stop discards it.
            if (strobe || (state != ST_RUN) || bus.stop) begin
                pending <= 1'b0;
            end else begin
                pending <= pend_eff;
            end

            if (strobe) begin
                frame_end <= last_bit;
            end else if (state_nxt != ST_RUN) begin
                frame_end <= 1'b0;
            end

            if (strobe) begin
                bits_sent <= bits_nxt;
            end

            if (strobe && inj && (err_cnt != ERR_MAX)) begin
                err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
            end
        end
    end

    // Output stage: one registered bit per strobe, zero between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            dout_p0 <= 1'b0;
        end else begin
            vld_p0  <= strobe;
            dout_p0 <= strobe && (fb ^ inj);
        end
    end

    assign bus.dout         = dout_p0;
    assign bus.dout_vld     = vld_p0;
    assign bus.busy         = (state == ST_RUN);
    assign bus.done         = (state == ST_DONE);
    assign bus.bits_sent    = bits_sent;
    assign bus.err_injected = err_cnt;

endmodule

// File: tb/tb_prbs_tx_gen.sv
// Scoreboard bench for prbs_tx_gen: a free-running PRBS7 instance and a
// FRAME_LEN=10 PRBS7 instance, with expected bits and arrival cycles queued.
module tb_prbs_tx_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prbs_tx_gen_if #(.ERR_CNT_WIDTH(16)) bus_a ();
    prbs_tx_gen_if #(.ERR_CNT_WIDTH(16)) bus_b ();

    prbs_tx_gen #(
        .PRBS_TYPE     (1),
        .SEED          (32'hFFFF_FFFF),
        .FRAME_LEN     (32'd0),
        .ERR_CNT_WIDTH (16)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    prbs_tx_gen #(
        .PRBS_TYPE     (1),
        .SEED          (32'hFFFF_FFFF),
        .FRAME_LEN     (32'd10),
        .ERR_CNT_WIDTH (16)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        logic b;
        int   c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    // Hand-computed PRBS7 bits 1..20 from an all-ones seed.
    int tab[20] = '{0, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 1, 1, 1, 0};
    int gold[0:160];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input int k);
        if (k <= 20) return tab[k-1][0];
        if (k >= 128 && k <= 136) return tab[k-128][0];
        return gold[6+k][0];
    endfunction

    task automatic push_a(input logic b, input int c);
        exp_t e;
        e.b = b;
        e.c = c;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic b, input int c);
        exp_t e;
        e.b = b;
        e.c = c;
        qb.push_back(e);
    endtask

    task automatic wait_drain(input int sel, input int budget);
        int n;
        n = 0;
        while ((((sel == 0) ? qa.size() : qb.size()) != 0) && (n < budget)) begin
            @(posedge clk);
            n++;
        end
        if (sel == 0) begin
            check("a_all_bits_seen", 64'(qa.size()), 64'd0);
            qa.delete();
        end else begin
            check("b_all_bits_seen", 64'(qb.size()), 64'd0);
            qb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.dout_vld) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_vld", 64'd1, 64'd0);
                end else begin
                    ea = qa.pop_front();
                    check("a_bit", 64'(bus_a.dout), 64'(ea.b));
                    check("a_bit_cycle", 64'(cyc), 64'(ea.c));
                end
            end else begin
                check("a_dout_idle", 64'(bus_a.dout), 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_b.dout_vld) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_vld", 64'd1, 64'd0);
                end else begin
                    eb = qb.pop_front();
                    check("b_bit", 64'(bus_b.dout), 64'(eb.b));
                    check("b_bit_cycle", 64'(cyc), 64'(eb.c));
                end
            end else begin
                check("b_dout_idle", 64'(bus_b.dout), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        for (int i = 0; i < 7; i++) gold[i] = 1;
        for (int n = 7; n <= 160; n++) gold[n] = gold[n-1] ^ gold[n-7];

        bus_a.start = 0; bus_a.stop = 0; bus_a.inj_err = 0;
        bus_a.rate_div = 8'd1; bus_a.err_period = 16'd0;
        bus_b.start = 0; bus_b.stop = 0; bus_b.inj_err = 0;
        bus_b.rate_div = 8'd4; bus_b.err_period = 16'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_dout_vld", 64'(bus_a.dout_vld), 64'd0);
        check("rst_dout", 64'(bus_a.dout), 64'd0);
        check("rst_busy", 64'(bus_a.busy), 64'd0);
        check("rst_done", 64'(bus_a.done), 64'd0);
        check("rst_bits_sent", 64'(bus_a.bits_sent), 64'd0);
        check("rst_err_injected", 64'(bus_a.err_injected), 64'd0);
        check("rst_b_busy", 64'(bus_b.busy), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Free run at rate 1 with an ignored start mid-run, then stop on a strobe.
        bus_a.start = 1; @(posedge clk); #1; bus_a.start = 0;
        s = cyc;
        for (int k = 1; k <= 136; k++) push_a(exp_bit(k), s + k - 1);
        check("a_busy_run", 64'(bus_a.busy), 64'd1);
        repeat (49) @(posedge clk);
        #1; bus_a.start = 1; @(posedge clk); #1; bus_a.start = 0;
        repeat (85) @(posedge clk);
        #1; bus_a.stop = 1; @(posedge clk); #1; bus_a.stop = 0;
        @(negedge clk);
        check("a_stop_no_vld", 64'(bus_a.dout_vld), 64'd0);
        check("a_stop_busy", 64'(bus_a.busy), 64'd0);
        check("a_stop_done", 64'(bus_a.done), 64'd0);
        check("a_stop_bits_sent", 64'(bus_a.bits_sent), 64'd136);
        wait_drain(0, 4);

        // Restart from seed with periodic injection plus a coincident manual one.
        bus_a.err_period = 16'd5;
        @(posedge clk); #1;
        bus_a.start = 1; @(posedge clk); #1; bus_a.start = 0;
        s = cyc;
        for (int k = 1; k <= 24; k++) push_a(exp_bit(k) ^ ((k % 5) == 0), s + k - 1);
        repeat (8) @(posedge clk);
        #1; bus_a.inj_err = 1; @(posedge clk); #1; bus_a.inj_err = 0;
        repeat (14) @(posedge clk);
        #1; bus_a.stop = 1; @(posedge clk); #1; bus_a.stop = 0;
        @(negedge clk);
        check("a_inj_err_injected", 64'(bus_a.err_injected), 64'd4);
        check("a_inj_bits_sent", 64'(bus_a.bits_sent), 64'd24);
        bus_a.err_period = 16'd0;
        wait_drain(0, 4);

        // rate_div of 0 behaves as 1.
        bus_a.rate_div = 8'd0;
        @(posedge clk); #1;
        bus_a.start = 1; @(posedge clk); #1; bus_a.start = 0;
        s = cyc;
        for (int k = 1; k <= 6; k++) push_a(exp_bit(k), s + k - 1);
        repeat (5) @(posedge clk);
        #1; bus_a.stop = 1; @(posedge clk); #1; bus_a.stop = 0;
        @(negedge clk);
        check("a_rate0_bits_sent", 64'(bus_a.bits_sent), 64'd6);
        bus_a.rate_div = 8'd1;
        wait_drain(0, 4);

        // Framed run: 10 bits every 4 cycles, then a one-cycle done.
        bus_b.start = 1; @(posedge clk); #1; bus_b.start = 0;
        s = cyc;
        for (int k = 1; k <= 10; k++) push_b(exp_bit(k), s + 4 * (k - 1));
        repeat (36) @(posedge clk);
        #1;
        @(negedge clk);
        check("b_last_busy", 64'(bus_b.busy), 64'd1);
        check("b_last_done", 64'(bus_b.done), 64'd0);
        @(negedge clk);
        check("b_done_pulse", 64'(bus_b.done), 64'd1);
        check("b_done_busy", 64'(bus_b.busy), 64'd0);
        @(negedge clk);
        check("b_done_cleared", 64'(bus_b.done), 64'd0);
        check("b_idle_busy", 64'(bus_b.busy), 64'd0);
        check("b_bits_sent", 64'(bus_b.bits_sent), 64'd10);
        wait_drain(1, 4);

        // Manual injection between strobes lands on the following bit.
        @(posedge clk); #1;
        bus_b.start = 1; @(posedge clk); #1; bus_b.start = 0;
        s = cyc;
        for (int k = 1; k <= 10; k++) push_b(exp_bit(k) ^ (k == 2), s + 4 * (k - 1));
        @(posedge clk); #1; bus_b.inj_err = 1; @(posedge clk); #1; bus_b.inj_err = 0;
        wait_drain(1, 60);
        repeat (4) @(posedge clk);
        #1;
        check("b_inj_err_injected", 64'(bus_b.err_injected), 64'd1);
        check("b_inj_bits_sent", 64'(bus_b.bits_sent), 64'd10);
        check("b_inj_done_idle", 64'(bus_b.done), 64'd0);

        // Asynchronous reset between edges during a run.
        @(posedge clk); #1;
        bus_a.start = 1; @(posedge clk); #1; bus_a.start = 0;
        s = cyc;
        for (int k = 1; k <= 20; k++) push_a(exp_bit(k), s + k - 1);
        repeat (4) @(posedge clk);
        #3; rst = 1'b1;
        #1;
        qa.delete();
        check("arst_dout_vld", 64'(bus_a.dout_vld), 64'd0);
        check("arst_dout", 64'(bus_a.dout), 64'd0);
        check("arst_busy", 64'(bus_a.busy), 64'd0);
        check("arst_done", 64'(bus_a.done), 64'd0);
        check("arst_bits_sent", 64'(bus_a.bits_sent), 64'd0);
        check("arst_err_injected", 64'(bus_a.err_injected), 64'd0);
        check("arst_b_err_injected", 64'(bus_b.err_injected), 64'd0);
        #3; rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("arst_stays_idle", 64'(bus_a.busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs_tx_gen.md
Name: prbs_tx_gen

Overview:
- Serial PRBS pattern generator that drives the din/din_vld input of the PRBS receiver/checker stage.
- Produces one bit per strobe using a selectable polynomial, with programmable bit rate, frame length and error injection.
- Uses the same tap recurrence as the checker, so the checker locks to its output without configuration.
- Used for loopback link tests and BER bring-up.

Parameters:
- PRBS_TYPE, 1, polynomial code: 0=PRBS3, 1=PRBS7, 2=PRBS9, 3=PRBS11, 4=PRBS15, 5=PRBS17, 6=PRBS23, 7=PRBS32.
- SEED, 32'hFFFF_FFFF, initial history register value; must be nonzero in the active taps.
- FRAME_LEN, 0, bits per run; 0 = free-running until stop.
- ERR_CNT_WIDTH, 16, width of the injected-error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a run from IDLE.
- stop  in  1  single-cycle pulse; aborts a run.
- rate_div  in  8  cycles between output bits; 0 is treated as 1.
- inj_err  in  1  single-cycle pulse; inverts the next output bit.
- err_period  in  16  periodic injection every N bits; 0 disables.
- dout  out  1  serial PRBS bit.
- dout_vld  out  1  dout valid, one cycle per bit.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a FRAME_LEN run completes.
- bits_sent  out  32  bits emitted in the current or last run; wraps modulo 2^32.
- err_injected  out  ERR_CNT_WIDTH  errors injected; saturates at all-ones.

Behaviour:
- Reset value of every output is 0. State resets to IDLE, history register H to SEED, and all counters to 0.
- Recurrence: H[0] holds the newest bit. Next bit g is the XOR of these taps of H:
  - PRBS3: H[2]^H[0]
  - PRBS7: H[6]^H[0]
  - PRBS9: H[8]^H[4]
  - PRBS11: H[10]^H[8]
  - PRBS15: H[14]^H[0]
  - PRBS17: H[16]^H[2]
  - PRBS23: H[22]^H[17]
  - PRBS32: H[31]^H[21]^H[1]^H[0]
- On each strobe, H shifts left with g entering H[0]. The injected inversion never enters H, so the sequence is not corrupted.
- FSM has states IDLE, RUN, DONE.
- IDLE -> RUN: on start. At that edge H reloads SEED, the rate counter is loaded so the first strobe occurs immediately, and bits_sent clears. err_injected is not cleared (cleared only by rst).
- RUN behaviour:
  - A strobe occurs every max(rate_div,1) cycles; rate_div is sampled at each strobe.
  - Each strobe registers dout = g ^ inj and dout_vld = 1 for exactly one cycle, and increments bits_sent.
  - dout_vld first goes high in the cycle after the start edge (latency 1).
- Injection rules:
  - inj_err sets a pending flag, which clears when consumed.
  - The periodic counter increments per strobe and fires when it equals err_period, then restarts at 1.
  - inj = pending OR periodic fire. Coincident sources inject and count once.
  - An inj_err arriving on a strobe cycle applies to that bit.
- RUN -> DONE: when FRAME_LEN != 0 and the FRAME_LEN-th bit strobes. DONE lasts one cycle with done=1, then goes to IDLE.
- RUN -> IDLE: on stop; stop wins over a simultaneous strobe, so no bit is emitted. The pending injection is discarded and done is not asserted.
- start while in RUN or DONE is ignored. start and stop in the same IDLE cycle: stay in IDLE.
- Parameters and rate_div/err_period changes take effect only at strobe boundaries. An asynchronous rst mid-run returns to IDLE immediately, with outputs cleared.
- dout is 0 whenever dout_vld is 0.

Decomposition:
- Shared package prbs_pkg holds:
  - polynomial code constants PRBS3..PRBS32;
  - the tap-XOR function of (code, H), also used by the checker;
  - the sequence-length constants (7, 127, 511, 2047, 32767, 131071, 8388607, 2^32-1).
- One natural sub-module: prbs_lfsr_core (H register, tap XOR, shift enable, load), reusable by the checker.

Test Plan:
- PRBS7, SEED all ones, rate_div=1, start -> first 9 dout bits 0,1,0,1,0,1,0,0,1 on consecutive cycles; bits 128..136 repeat bits 1..9.
- rate_div=4, FRAME_LEN=10 -> 10 dout_vld pulses spaced 4 cycles apart, done high one cycle after the 10th, busy low next, bits_sent=10.
- err_period=5 plus an inj_err coinciding with bit 10, over 20 bits -> bits 5,10,15,20 inverted versus the golden sequence; err_injected=4; later bits are uncorrupted.
- Generator looped into the downstream PRBS checker, all PRBS_TYPE values -> checker syncs; error count increments exactly once per injected bit.
- stop mid-run at a strobe cycle -> no dout_vld that cycle, busy low, done stays low; a new start restarts from SEED (first PRBS7 bit 0).
- rst asserted asynchronously mid-run between clock edges -> all outputs 0 immediately, state IDLE, err_injected=0.
